psmac_pipelined: RTL and testbench

- Pipelined, precision-scalable multiply-accumulate unit built on one W×W multiplier array.
- Each beat runs in one of three modes: one full-width lane, two half lanes, or four quarter lanes.
- Each lane has its own accumulator, overflow flag and signedness control.
- Sits in the PIRDSP datapath between operand fetch and result writeback, with valid/ready handshakes on both sides.

---
 rtl/psmac_pkg.sv | 34 +++
 rtl/psmac_lane_acc.sv | 66 ++++++
 rtl/psmac_pipelined.sv | 202 ++++++++++++++++++++
 tb/tb_psmac_pipelined.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psmac_pkg.sv
// psmac_pkg: mode encodings and width helpers
// shared by the precision-scalable MAC.
package psmac_pkg;

  localparam logic [1:0] MODE_FULL    = 2'b00;
  localparam logic [1:0] MODE_HALF    = 2'b01;
  localparam logic [1:0] MODE_QUARTER = 2'b10;

  function automatic int h_of(input int q);
    return 2 * q;
  endfunction

  function automatic int w_of(input int q);
    return 4 * q + 1;
  endfunction

  function automatic int sw_of(
    input logic [1:0] m,
    input int q,
    input int g
  );
    if (m == MODE_HALF)
      return 4 * q + g;
    else if (m == MODE_QUARTER)
      return 2 * q + g;
    else
      return 8 * q + 2 + g;
  endfunction

  function automatic int acc_of(input int q, input int g);
    return 8 * q + 4 * g;
  endfunction

endpackage

// File: rtl/psmac_lane_acc.sv
// psmac_lane_acc: one accumulator slot whose width
// and overflow rule are chosen per beat by mode.
module psmac_lane_acc
  import psmac_pkg::*;
#(
  parameter int Q_WIDTH = 2,
  parameter int GUARD = 4,
  localparam int SWM = sw_of(MODE_FULL, Q_WIDTH, GUARD)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           load,
  input  logic           sgn,
  input  logic [1:0]     mode,
  input  logic [SWM-1:0] prod,
  output logic [SWM-1:0] acc,
  output logic           ovf
);

  localparam int IW = $clog2(SWM + 1);
  localparam int SH = sw_of(MODE_HALF, Q_WIDTH, GUARD);
  localparam int SQ = sw_of(MODE_QUARTER, Q_WIDTH, GUARD);

  logic [IW-1:0]  sw;
  logic [IW-1:0]  top;
  logic [SWM-1:0] mask;
  logic [SWM-1:0] a;
  logic [SWM-1:0] b;
  logic [SWM:0]   s;
  logic           carry;
  logic           sovf;

  always_comb begin
    unique case (1'b1)
      (mode == MODE_HALF):    sw = IW'(SH);
      (mode == MODE_QUARTER): sw = IW'(SQ);
      default:                sw = IW'(SWM);
    endcase
    top = sw - 1'b1;
    mask = '0;
    for (int i = 0; i < SWM; i++)
      mask[i] = (i < int'(sw));
    a = acc & mask;
    b = prod & mask;
    s = {1'b0, a} + {1'b0, b};
    carry = s[sw];
    sovf = (a[top] == b[top]) && (s[top] != a[top]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (load) begin
        acc <= b;
        ovf <= 1'b0;
      end else begin
        acc <= s[SWM-1:0] & mask;
        ovf <= ovf | (sgn ? sovf : carry);
      end
    end
  end

endmodule

// File: rtl/psmac_pipelined.sv
// psmac_pipelined: 3-stage precision-scalable MAC
// (operands -> lane products -> accumulators).
module psmac_pipelined
  import psmac_pkg::*;
#(
  parameter int Q_WIDTH = 2,
  parameter int GUARD = 4,
  localparam int W = w_of(Q_WIDTH),
  localparam int PW = 2 * W,
  localparam int AW = acc_of(Q_WIDTH, GUARD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic          A_sign,
  input  logic          B_sign,
  input  logic [1:0]    mode,
  input  logic          acc_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] P,
  output logic [AW-1:0] ACC,
  output logic [3:0]    ovf,
  output logic [1:0]    out_mode
);

  localparam int Q = Q_WIDTH;
  localparam int H = h_of(Q_WIDTH);
  localparam int SWM = sw_of(MODE_FULL, Q_WIDTH, GUARD);
  localparam int SH = sw_of(MODE_HALF, Q_WIDTH, GUARD);
  localparam int SQ = sw_of(MODE_QUARTER, Q_WIDTH, GUARD);

  logic advance;
  assign advance = !out_valid || out_ready;
  assign in_ready = advance;

  logic           v1, as1, bs1, e1;
  logic [W-1:0]   a1, b1;
  logic [1:0]     m1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      as1 <= 1'b0;
      bs1 <= 1'b0;
      e1 <= 1'b0;
      m1 <= MODE_FULL;
    end else if (advance) begin
      v1 <= in_valid;
      a1 <= A;
      b1 <= B;
      as1 <= A_sign;
      bs1 <= B_sign;
      e1 <= acc_en;
      m1 <= (mode == MODE_HALF || mode == MODE_QUARTER)
            ? mode : MODE_FULL;
    end
  end

  // lanes are sign/zero-extended to W, products kept exact in PW
  logic [W-1:0]   la [4];
  logic [W-1:0]   lb [4];
  logic [PW-1:0]  pr [4];
  logic [SWM-1:0] px [4];
  logic [PW-1:0]  pk;
  logic           psg;

  always_comb begin
    psg = as1 | bs1;
    for (int k = 0; k < 4; k++) begin
      la[k] = '0;
      lb[k] = '0;
    end
    unique case (1'b1)
      (m1 == MODE_HALF): begin
        la[1] = {{(W-H){as1 & a1[W-1]}}, a1[W-1 -: H]};
        la[0] = {{(W-H){as1 & a1[H-1]}}, a1[H-1:0]};
        lb[1] = {{(W-H){bs1 & b1[W-1]}}, b1[W-1 -: H]};
        lb[0] = {{(W-H){bs1 & b1[H-1]}}, b1[H-1:0]};
      end
      (m1 == MODE_QUARTER): begin
        la[3] = {{(W-Q){as1 & a1[W-1]}}, a1[W-1 -: Q]};
        la[2] = {{(W-Q){as1 & a1[W-1-Q]}}, a1[W-1-Q -: Q]};
        la[1] = {{(W-Q){as1 & a1[H-1]}}, a1[H-1 -: Q]};
        la[0] = {{(W-Q){as1 & a1[Q-1]}}, a1[Q-1:0]};
        lb[3] = {{(W-Q){bs1 & b1[W-1]}}, b1[W-1 -: Q]};
        lb[2] = {{(W-Q){bs1 & b1[W-1-Q]}}, b1[W-1-Q -: Q]};
        lb[1] = {{(W-Q){bs1 & b1[H-1]}}, b1[H-1 -: Q]};
        lb[0] = {{(W-Q){bs1 & b1[Q-1]}}, b1[Q-1:0]};
      end
      default: begin
        la[0] = a1;
        lb[0] = b1;
      end
    endcase
    for (int k = 0; k < 4; k++) begin
      pr[k] = {{W{as1 & la[k][W-1]}}, la[k]}
            * {{W{bs1 & lb[k][W-1]}}, lb[k]};
      px[k] = {{(SWM-PW){psg & pr[k][PW-1]}}, pr[k]};
    end
    pk = '0;
    unique case (1'b1)
      (m1 == MODE_HALF): begin
        pk[PW-1 -: 2*H] = pr[1][2*H-1:0];
        pk[2*H-1:0] = pr[0][2*H-1:0];
      end
      (m1 == MODE_QUARTER): begin
        pk[PW-1 -: 2*Q] = pr[3][2*Q-1:0];
        pk[PW-1-2*Q -: 2*Q] = pr[2][2*Q-1:0];
        pk[2*H-1 -: 2*Q] = pr[1][2*Q-1:0];
        pk[2*Q-1:0] = pr[0][2*Q-1:0];
      end
      default: pk = pr[0];
    endcase
  end

  logic           v2, e2, sg2;
  logic [1:0]     m2;
  logic [PW-1:0]  p2;
  logic [SWM-1:0] x2 [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      v2 <= 1'b0;
      e2 <= 1'b0;
      sg2 <= 1'b0;
      m2 <= MODE_FULL;
      p2 <= '0;
      for (int k = 0; k < 4; k++)
        x2[k] <= '0;
    end else if (advance) begin
      v2 <= v1;
      e2 <= e1;
      sg2 <= psg;
      m2 <= m1;
      p2 <= pk;
      for (int k = 0; k < 4; k++)
        x2[k] <= px[k];
    end
  end

  // out_mode doubles as the stored accumulating mode
  logic           ld;
  logic [SWM-1:0] sl [4];
  logic [3:0]     ov;

  assign ld = !e2 || (m2 != out_mode);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      P <= '0;
      out_mode <= MODE_FULL;
    end else if (advance) begin
      out_valid <= v2;
      if (v2) begin
        P <= p2;
        out_mode <= m2;
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    psmac_lane_acc #(
      .Q_WIDTH(Q_WIDTH),
      .GUARD(GUARD)
    ) u_acc (
      .clk(clk),
      .reset(reset),
      .en(advance & v2),
      .load(ld),
      .sgn(sg2),
      .mode(m2),
      .prod(x2[k]),
      .acc(sl[k]),
      .ovf(ov[k])
    );
  end

  assign ovf = ov;

  always_comb begin
    ACC = '0;
    unique case (1'b1)
      (out_mode == MODE_HALF): begin
        ACC[SH-1:0] = sl[0][SH-1:0];
        ACC[2*SH-1 -: SH] = sl[1][SH-1:0];
      end
      (out_mode == MODE_QUARTER): begin
        for (int k = 0; k < 4; k++)
          ACC[k*SQ +: SQ] = sl[k][SQ-1:0];
      end
      default: ACC[SWM-1:0] = sl[0];
    endcase
  end

endmodule

// File: tb/tb_psmac_pipelined.sv
// tb_psmac_pipelined: random and directed beats checked
// through an expected-result queue against a lane-level model.
module tb_psmac_pipelined;

  localparam int W = 9;
  localparam int PW = 18;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          A_sign;
  logic          B_sign;
  logic [1:0]    mode;
  logic          acc_en;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] P;
  logic [AW-1:0] ACC;
  logic [3:0]    ovf;
  logic [1:0]    out_mode;

  psmac_pipelined #(.Q_WIDTH(2), .GUARD(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .A_sign(A_sign),
    .B_sign(B_sign),
    .mode(mode),
    .acc_en(acc_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .P(P),
    .ACC(ACC),
    .ovf(ovf),
    .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] p;
    logic [AW-1:0] acc;
    logic [3:0]    ovf;
    logic [1:0]    m;
  } exp_t;

  exp_t sq[$];

  int checks = 0;
  int passes = 0;
  int out_cnt = 0;
  int stall_n = 0;
  bit rnd_ready = 0;
  bit bp_chk = 0;

  logic [PW-1:0] last_p;
  logic [AW-1:0] last_acc;
  logic [3:0]    last_ovf;

  // model state: raw slot bits, sticky flags, accumulating mode
  longint slot[4];
  bit     mo[4];
  logic [1:0] smode;

  task automatic chk(input bit ok, input string name, input string info);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, info);
  endtask

  task automatic model_reset();
    sq.delete();
    for (int k = 0; k < 4; k++) begin
      slot[k] = 0;
      mo[k] = 0;
    end
    smode = 2'd0;
  endtask

  task automatic model_push(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input bit as,
    input bit bs,
    input logic [1:0] m,
    input bit en
  );
    int n, nl, sw;
    int off[4];
    int pof[4];
    longint one, va, vb, pr, mask, cur, sum, pv, av;
    bit ld, sg;
    exp_t e;
    one = 1;
    pv = 0;
    av = 0;
    if (m == 2'd1) begin
      n = 4; nl = 2; sw = 12;
      off = '{0, 5, 0, 0}; pof = '{0, 10, 0, 0};
    end else if (m == 2'd2) begin
      n = 2; nl = 4; sw = 8;
      off = '{0, 2, 5, 7}; pof = '{0, 4, 10, 14};
    end else begin
      n = 9; nl = 1; sw = 22;
      off = '{0, 0, 0, 0}; pof = '{0, 0, 0, 0};
    end
    ld = !en || (m != smode);
    sg = as | bs;
    mask = (one << sw) - 1;
    for (int k = 0; k < 4; k++) begin
      va = 0;
      vb = 0;
      if (k < nl) begin
        va = (longint'(a) >> off[k]) & ((one << n) - 1);
        vb = (longint'(b) >> off[k]) & ((one << n) - 1);
        if (as && va >= (one << (n - 1))) va -= (one << n);
        if (bs && vb >= (one << (n - 1))) vb -= (one << n);
      end
      pr = va * vb;
      pv |= (pr & ((one << (2 * n)) - 1)) << pof[k];
      if (ld) begin
        slot[k] = pr & mask;
        mo[k] = 0;
      end else begin
        if (sg) begin
          cur = (slot[k] >= (one << (sw - 1))) ? slot[k] - (one << sw) : slot[k];
          sum = cur + pr;
          if (sum >= (one << (sw - 1)) || sum < -(one << (sw - 1))) mo[k] = 1;
        end else begin
          sum = slot[k] + pr;
          if (sum >= (one << sw)) mo[k] = 1;
        end
        slot[k] = sum & mask;
      end
      if (k < nl) av |= slot[k] << (k * sw);
    end
    smode = m;
    e.p = pv[PW-1:0];
    e.acc = av[AW-1:0];
    e.ovf = {mo[3], mo[2], mo[1], mo[0]};
    e.m = m;
    sq.push_back(e);
  endtask

  // called at posedge+1; returns at posedge+1 after acceptance
  task automatic send(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input bit as,
    input bit bs,
    input logic [1:0] m,
    input bit en
  );
    int t;
    t = 0;
    A = a; B = b; A_sign = as; B_sign = bs;
    mode = m; acc_en = en; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready)
      chk(1'b0, "accept_timeout", "in_ready stuck low");
    else
      model_push(a, b, as, bs, m, en);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(sq.size() == 0, "drain",
        $sformatf("%0d results still pending", sq.size()));
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_n > 0) begin
        out_ready = 1'b0;
        stall_n--;
      end else if (rnd_ready)
        out_ready = ($urandom_range(0, 3) != 0);
      else
        out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      out_cnt++;
      if (sq.size() == 0)
        chk(1'b0, "unexpected_output",
            $sformatf("P=%h ACC=%h with nothing expected", P, ACC));
      else begin
        e = sq.pop_front();
        chk(P == e.p && ACC == e.acc && ovf == e.ovf && out_mode == e.m,
            "scoreboard",
            $sformatf("got P=%h ACC=%h ovf=%b mode=%0d, want P=%h ACC=%h ovf=%b mode=%0d",
                      P, ACC, ovf, out_mode, e.p, e.acc, e.ovf, e.m));
        last_p = P;
        last_acc = ACC;
        last_ovf = ovf;
      end
    end
    if (bp_chk)
      chk(in_ready == !(out_valid && !out_ready), "in_ready_stall",
          $sformatf("in_ready=%b out_valid=%b out_ready=%b",
                    in_ready, out_valid, out_ready));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1;
    in_valid = 1'b0;
    A = '0; B = '0; A_sign = 1'b0; B_sign = 1'b0;
    mode = 2'd0; acc_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "reset_out_valid", $sformatf("got %b want 0", out_valid));
    chk(P == '0, "reset_P", $sformatf("got %h want 0", P));
    chk(ACC == '0, "reset_ACC", $sformatf("got %h want 0", ACC));
    chk(ovf == 4'd0, "reset_ovf", $sformatf("got %b want 0000", ovf));
    chk(in_ready == 1'b1, "reset_in_ready", $sformatf("got %b want 1", in_ready));
    @(posedge clk);
    #1;

    send(9'd511, 9'd511, 0, 0, 2'd0, 0);
    drain();
    chk(last_p == 18'h3FC01, "full_unsigned_P", $sformatf("got %h want 3fc01", last_p));
    chk(last_acc == 32'h0003FC01, "full_unsigned_ACC", $sformatf("got %h want 0003fc01", last_acc));

    send(9'h100, 9'h100, 1, 1, 2'd0, 0);
    send(9'h100, 9'h100, 1, 1, 2'd0, 1);
    send(9'h100, 9'h100, 1, 1, 2'd0, 1);
    drain();
    chk(last_acc == 32'd196608, "full_signed_ACC", $sformatf("got %0d want 196608", last_acc));
    chk(last_ovf == 4'd0, "full_signed_ovf", $sformatf("got %b want 0000", last_ovf));

    send(9'b101100110, 9'b101100110, 1, 1, 2'd2, 0);
    drain();
    chk(last_p == 18'b0100_0001_00_0001_0100, "quarter_P", $sformatf("got %b", last_p));
    chk(last_acc == 32'h04010104, "quarter_ACC", $sformatf("got %h want 04010104", last_acc));

    send(9'b1111_0_1111, 9'b1111_0_1111, 0, 0, 2'd1, 0);
    for (int i = 0; i < 18; i++)
      send(9'b1111_0_1111, 9'b1111_0_1111, 0, 0, 2'd1, 1);
    drain();
    chk(last_acc == 32'h000B30B3, "half_ovf_ACC", $sformatf("got %h want 000b30b3", last_acc));
    chk(last_ovf == 4'b0011, "half_ovf_flags", $sformatf("got %b want 0011", last_ovf));

    c0 = out_cnt;
    bp_chk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        @(negedge clk);
        stall_n = 5;
        @(posedge clk);
        #1;
      end
      send(9'($urandom), 9'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom_range(0, 2)), ($urandom_range(0, 3) != 0));
    end
    drain();
    bp_chk = 1'b0;
    chk(out_cnt - c0 == 10, "bp_count", $sformatf("got %0d outputs want 10", out_cnt - c0));

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++)
      send(9'($urandom), 9'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom_range(0, 2)), ($urandom_range(0, 3) != 0));
    drain();
    rnd_ready = 1'b0;

    send(9'd300, 9'd77, 0, 0, 2'd0, 0);
    send(9'd12, 9'd99, 0, 0, 2'd0, 1);
    send(9'd5, 9'd5, 0, 0, 2'd0, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "midreset_out_valid", $sformatf("got %b want 0", out_valid));
    chk(ACC == '0, "midreset_ACC", $sformatf("got %h want 0", ACC));
    @(posedge clk);
    #1;
    repeat (6) @(posedge clk);
    #1;
    send(9'd3, 9'd7, 0, 0, 2'd0, 1);
    drain();
    chk(last_acc == 32'd21, "post_reset_acc", $sformatf("got %0d want 21", last_acc));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
